usb_ctl_router: RTL

//  Routes USB control transfers decoded by usb_xfer to one of CHANNELS request handlers
//  (channel 0 = usb_std_request, 1.. = class/vendor handlers) and replaces the

---
 rtl/usb_ctl_pkg.sv | 21 ++
 rtl/usb_ctl_router.sv | 132 +++++++++++++
 2 files changed

// File: rtl/usb_ctl_pkg.sv
// Shared definitions for the USB control-transfer router: bmRequestType
// field masks, request-type codes and the router state encoding.
package usb_ctl_pkg;

  localparam logic [7:0] RT_DIR_MASK    = 8'h80;
  localparam logic [7:0] RT_TYPE_MASK   = 8'h60;
  localparam logic [7:0] RT_RECIP_MASK  = 8'h1F;

  localparam logic [7:0] RT_TYPE_STD    = 8'h00;
  localparam logic [7:0] RT_TYPE_CLASS  = 8'h20;
  localparam logic [7:0] RT_TYPE_VENDOR = 8'h40;

  typedef enum logic [2:0] {
    RT_IDLE,
    RT_MATCH,
    RT_WAIT,
    RT_ACTIVE,
    RT_STALL
  } rt_state_e;

endpackage

// File: rtl/usb_ctl_router.sv
// Steers one USB control transfer at a time to the handler channel whose
// bmRequestType/endpoint filter claims it; unclaimed or ungranted requests stall.
module usb_ctl_router
  import usb_ctl_pkg::*;
#(
  parameter int unsigned             CHANNELS    = 2,
  parameter logic [8*CHANNELS-1:0]   TYPE_MASK   = {RT_TYPE_MASK, RT_TYPE_MASK},
  parameter logic [8*CHANNELS-1:0]   TYPE_MATCH  = {RT_TYPE_CLASS, RT_TYPE_STD},
  parameter logic [16*CHANNELS-1:0]  EP_MASK     = 32'hFFFF_0001,
  parameter int unsigned             GNT_TIMEOUT = 255
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    xfer_req_i,
  input  logic [3:0]              xfer_ep_i,
  input  logic [7:0]              xfer_type_i,
  output logic                    xfer_accept_o,
  output logic                    xfer_done_o,
  output logic                    xfer_stall_o,
  input  logic                    xfer_dout_valid_i,
  output logic                    m_tvalid_o,
  input  logic                    m_tready_i,
  output logic                    m_tlast_o,
  output logic [7:0]              m_tdata_o,
  output logic [CHANNELS-1:0]     ch_req_o,
  input  logic [CHANNELS-1:0]     ch_gnt_i,
  input  logic [CHANNELS-1:0]     ch_done_i,
  output logic [CHANNELS-1:0]     ch_dout_valid_o,
  input  logic [CHANNELS-1:0]     ch_tvalid_i,
  input  logic [CHANNELS-1:0]     ch_tlast_i,
  output logic [CHANNELS-1:0]     ch_tready_o,
  input  logic [8*CHANNELS-1:0]   ch_tdata_i
);

  localparam int unsigned SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned TW = $clog2(GNT_TIMEOUT + 1);

  // Returns {hit, index}; scanning downward lets the lowest channel win.
  function automatic logic [SW:0] prio_match(input logic [7:0] rtype, input logic [3:0] ep);
    logic [SW:0] r;
    r = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (((rtype & TYPE_MASK[8*c +: 8]) == TYPE_MATCH[8*c +: 8]) && EP_MASK[16*c + int'(ep)])
        r = {1'b1, SW'(c)};
    end
    return r;
  endfunction

  rt_state_e       state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            req_prev_q, req_prev_d;
  logic            stall_q, stall_d;
  logic [SW:0]     mres;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RT_IDLE;
      sel_q      <= '0;
      timer_q    <= '0;
      req_prev_q <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      timer_q    <= timer_d;
      req_prev_q <= req_prev_d;
      stall_q    <= stall_d;
    end
  end

  // Timer defaults to zero so it clears whenever the FSM is not counting in WAIT.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    timer_d    = '0;
    stall_d    = 1'b0;
    req_prev_d = xfer_req_i;
    mres       = prio_match(xfer_type_i, xfer_ep_i);
    unique case (state_q)
      RT_IDLE: if (xfer_req_i && !req_prev_q) state_d = RT_MATCH;
      RT_MATCH: begin
        if (!xfer_req_i) begin
          state_d = RT_IDLE;
        end else if (mres[SW]) begin
          sel_d   = mres[SW-1:0];
          state_d = RT_WAIT;
        end else begin
          state_d = RT_STALL;
          stall_d = 1'b1;
        end
      end
      RT_WAIT: begin
        if (!xfer_req_i) begin
          state_d = RT_IDLE;
        end else if (ch_gnt_i[sel_q]) begin
          state_d = RT_ACTIVE;
        end else if (timer_q == TW'(GNT_TIMEOUT - 1)) begin
          state_d = RT_STALL;
          stall_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RT_ACTIVE: if (!xfer_req_i) state_d = RT_IDLE;
      RT_STALL:  if (!xfer_req_i) state_d = RT_IDLE;
      default:   state_d = RT_IDLE;
    endcase
  end

  // Request, accept and stream are gated by xfer_req_i so an abort drops them at once.
  logic in_wait, in_act;
  assign in_wait = (state_q == RT_WAIT) && xfer_req_i;
  assign in_act  = (state_q == RT_ACTIVE) && xfer_req_i;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic is_sel;
    assign is_sel             = (sel_q == SW'(c));
    assign ch_req_o[c]        = is_sel & (in_wait | in_act);
    assign ch_tready_o[c]     = is_sel & in_act & m_tready_i;
    assign ch_dout_valid_o[c] = is_sel & in_act & xfer_dout_valid_i;
  end

  assign m_tvalid_o    = in_act & ch_tvalid_i[sel_q];
  assign m_tlast_o     = in_act & ch_tlast_i[sel_q];
  assign m_tdata_o     = in_act ? ch_tdata_i[8*sel_q +: 8] : 8'h00;
  assign xfer_accept_o = in_act;
  assign xfer_stall_o  = stall_q;
  assign xfer_done_o   = (state_q == RT_STALL) |
                         ((state_q == RT_ACTIVE) & ch_done_i[sel_q]);

endmodule
